debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel debouncer for the board's push-buttons and sensor inputs (reset button, test, energy, medicine, ultrasonic, photocell). Each channel gets a synchroniser, a per-channel debounce FSM with a selectable fast or slow constant, and optional active-low inversion. Per channel it produces a clean level, one-cycle rise and fall pulses, a toggle bit that flips on release, and a one-shot long-press pulse. It replaces the per-signal debounce instances and `negedge`-clocked toggle logic with a single fully synchronous block in the `clk` domain.

## Interface
- N_CH, 6, number of channels
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEB_FAST, 10000, debounce cycles for fast channels (≥2)
- DEB_SLOW, 250000000, debounce cycles for slow channels (≥2)
- SLOW_MASK, {N_CH{1'b0}}, bit i=1 → channel i uses DEB_SLOW
- ACTIVE_LOW_MASK, {N_CH{1'b0}}, bit i=1 → raw input i inverted after synchronisation
- LONG_CYCLES, 0, held-pressed cycles before long_pulse; 0 disables long-press
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- raw_in  input  N_CH  asynchronous raw button/sensor inputs
- clr_toggle  input  N_CH  synchronous clear of toggle bits
- level  output  N_CH  debounced active-high level
- rise_pulse  output  N_CH  1-cycle pulse when level goes 0→1
- fall_pulse  output  N_CH  1-cycle pulse when level goes 1→0
- toggle  output  N_CH  flips on each fall_pulse
- long_pulse  output  N_CH  1-cycle pulse, at most once per press

## Operation
- Per channel: raw → SYNC_STAGES flops → optional inversion (ACTIVE_LOW_MASK) → s; FSM on s; DEB = DEB_SLOW if SLOW_MASK[i] else DEB_FAST.
- FSM states: IDLE (level 0), PRESS_WAIT, PRESSED (level 1), RELEASE_WAIT.
- IDLE: s=1 → PRESS_WAIT, cnt←1.
- PRESS_WAIT: s=0 → IDLE, cnt←0, no pulse; s=1 with cnt==DEB-1 → PRESSED, cnt←0, level←1, rise_pulse; else cnt←cnt+1.
- PRESSED: s=0 → RELEASE_WAIT, cnt←1.
- RELEASE_WAIT: s=1 → PRESSED, cnt←0, no pulse; s=0 with cnt==DEB-1 → IDLE, cnt←0, level←0, fall_pulse, toggle flips; else cnt←cnt+1.
- Debounce counter width: clog2(max(DEB_FAST,DEB_SLOW)); it never exceeds DEB-1.
- Hold counter (separate, per channel): cleared when entering PRESSED from PRESS_WAIT; increments each cycle in PRESSED or RELEASE_WAIT and saturates at LONG_CYCLES. long_pulse fires on the cycle the counter reaches LONG_CYCLES, so a press with an absorbed release glitch keeps counting. Cleared on fall_pulse.
- clr_toggle[i]=1 → toggle[i]←0 next edge; if it coincides with fall_pulse[i], clear wins (toggle=0).
- Channels are fully independent; simultaneous events on different channels are each handled in the same cycle.

## Timing
- Reset (reset=0, async): all synchroniser flops 0, all FSMs IDLE, counters 0, and every output (level, rise_pulse, fall_pulse, toggle, long_pulse) is 0.
- Active-low channel: the synchroniser holds 0, so after inversion s=1 during the first cycles out of reset. If the pin is idle-high, the channel sees no press; if the pin is held low, the channel debounces it as a press normally.
- Reset assertion mid-press drops level immediately without a fall_pulse or toggle change. Release of reset is synchronous to the next clk edge.
- Latency: counting the edge that first samples the new raw value as edge 1, level, rise_pulse and fall_pulse update on edge SYNC_STAGES+DEB, provided s holds the new value throughout.
- A pulse shorter than DEB cycles at s never changes level.
- rise_pulse and fall_pulse are high exactly one cycle, coincident with the level edge.
- long_pulse asserts LONG_CYCLES edges after rise_pulse and never in the same cycle as rise_pulse (LONG_CYCLES≥1).
- toggle changes in the same cycle as fall_pulse.

## Test plan
Bench parameters: N_CH=3, SYNC_STAGES=2, DEB_FAST=4, DEB_SLOW=8, SLOW_MASK=3'b100, ACTIVE_LOW_MASK=3'b010, LONG_CYCLES=20.
- Reset: drive reset=0 with raw_in=3'b111 → all outputs 0; release reset → after the raw samples propagate, ch0 level=1 on edge 6 and ch2 level=1 on edge 10; ch1 (active-low input high) stays 0.
- Clean press ch0: raw_in[0] 0→1, held → rise_pulse[0] for exactly 1 cycle on edge 6; release held → fall_pulse[0] on edge 6 after release and toggle[0]=1.
- Bounce: raw_in[0] high 3 cycles, low 1, high 3, low → level[0] stays 0, no pulses; then glitch of 2 cycles low while pressed → level stays 1, no fall_pulse.
- Slow/inverted channels: raw_in[1] driven 1→0 and held → level[1] rises on edge 6; raw_in[2] 0→1 held → level[2] rises on edge 10; a 7-cycle pulse on ch2 is rejected.
- Long press: hold ch0 for 40 cycles → exactly one long_pulse[0], 20 edges after rise_pulse[0]; a 2-cycle glitch at cycle 10 does not restart the count.
- Toggle clear and reset: clr_toggle[0] in the same cycle as fall_pulse[0] → toggle[0]=0. Assert reset while level[0]=1 → level[0]=0 immediately, and no fall_pulse or toggle change.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel button/sensor debouncer: per-channel synchroniser, debounce FSM,
// clean level, rise/fall pulses, release toggle and one-shot long-press pulse.
module debounce_bank #(
   parameter int unsigned          N_CH            = 6,
   parameter int unsigned          SYNC_STAGES     = 2,
   parameter int unsigned          DEB_FAST        = 10000,
   parameter int unsigned          DEB_SLOW        = 250000000,
   parameter logic [N_CH-1:0]      SLOW_MASK       = '0,
   parameter logic [N_CH-1:0]      ACTIVE_LOW_MASK = '0,
   parameter int unsigned          LONG_CYCLES     = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   input  logic [N_CH-1:0] clr_toggle,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic [N_CH-1:0] toggle,
   output logic [N_CH-1:0] long_pulse
);

   localparam int unsigned DEB_MAX = (DEB_FAST > DEB_SLOW) ? DEB_FAST : DEB_SLOW;
   localparam int unsigned CNT_W   = $clog2(DEB_MAX);
   localparam int unsigned HOLD_W  = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   logic [N_CH-1:0]   sync_q [SYNC_STAGES];
   logic [N_CH-1:0]   sync_d [SYNC_STAGES];
   state_t            state_q [N_CH];
   state_t            state_d [N_CH];
   logic [CNT_W-1:0]  cnt_q [N_CH];
   logic [CNT_W-1:0]  cnt_d [N_CH];
   logic [HOLD_W-1:0] hold_q [N_CH];
   logic [HOLD_W-1:0] hold_d [N_CH];
   logic [N_CH-1:0]   level_q, level_d;
   logic [N_CH-1:0]   rise_q, rise_d;
   logic [N_CH-1:0]   fall_q, fall_d;
   logic [N_CH-1:0]   toggle_q, toggle_d;
   logic [N_CH-1:0]   long_q, long_d;
   logic [N_CH-1:0]   s;

   // Inversion happens after the synchroniser, so an active-low channel sees
   // s=1 briefly out of reset; the debounce window swallows it.
   assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK;

   always_comb begin
      sync_d[0] = raw_in;
      for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
         sync_d[st] = sync_q[st-1];
      end
   end

   always_comb begin
      logic [CNT_W-1:0] last;
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      level_d  = level_q;
      rise_d   = '0;
      fall_d   = '0;
      toggle_d = toggle_q;
      long_d   = '0;
      last     = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         last = SLOW_MASK[i] ? CNT_W'(DEB_SLOW - 1) : CNT_W'(DEB_FAST - 1);
         case (state_q[i])
            IDLE: begin
               if (s[i]) begin
                  state_d[i] = PRESS_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            PRESS_WAIT: begin
               if (!s[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == last) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  rise_d[i]  = 1'b1;
                  hold_d[i]  = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!s[i]) begin
                  state_d[i] = RELEASE_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            RELEASE_WAIT: begin
               if (s[i]) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == last) begin
                  state_d[i]  = IDLE;
                  cnt_d[i]    = '0;
                  level_d[i]  = 1'b0;
                  fall_d[i]   = 1'b1;
                  toggle_d[i] = ~toggle_q[i];
                  hold_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: state_d[i] = IDLE;
         endcase

         // Hold count spans absorbed release glitches; saturation gives one pulse per press.
         if ((LONG_CYCLES != 0) && !fall_d[i] &&
             ((state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT)) &&
             (hold_q[i] < HOLD_W'(LONG_CYCLES))) begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
            if (hold_d[i] == HOLD_W'(LONG_CYCLES)) begin
               long_d[i] = 1'b1;
            end
         end

         if (clr_toggle[i]) begin
            toggle_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned st = 0; st < SYNC_STAGES; st++) begin
            sync_q[st] <= '0;
         end
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            hold_q[i]  <= '0;
         end
         level_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         toggle_q <= '0;
         long_q   <= '0;
      end else begin
         for (int unsigned st = 0; st < SYNC_STAGES; st++) begin
            sync_q[st] <= sync_d[st];
         end
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            hold_q[i]  <= hold_d[i];
         end
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         toggle_q <= toggle_d;
         long_q   <= long_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign toggle     = toggle_q;
   assign long_pulse = long_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: run-length debounce model checked every
// cycle, plus hand-computed expectations for latency, bounce, long press, reset.
module tb_debounce_bank;

   localparam int unsigned N    = 3;
   localparam logic [2:0]  SLOW = 3'b100;
   localparam logic [2:0]  AL   = 3'b010;
   localparam int          LONG = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] raw_in = 3'b111;
   logic [2:0] clr_toggle = 3'b000;
   logic [2:0] level, rise_pulse, fall_pulse, toggle, long_pulse;

   int total = 0;
   int bad   = 0;

   debounce_bank #(
      .N_CH(N), .SYNC_STAGES(2), .DEB_FAST(4), .DEB_SLOW(8),
      .SLOW_MASK(SLOW), .ACTIVE_LOW_MASK(AL), .LONG_CYCLES(LONG)
   ) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in), .clr_toggle(clr_toggle),
      .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .toggle(toggle), .long_pulse(long_pulse)
   );

   always #5 clk = ~clk;

   // Model: s is the raw value from two edges earlier; level flips after DEB
   // consecutive samples disagreeing with it.
   logic [2:0] hist0 = '0, hist1 = '0;
   logic [2:0] m_level = '0, m_rise = '0, m_fall = '0, m_tog = '0, m_long = '0;
   int         run [3] = '{0, 0, 0};
   int         age [3] = '{0, 0, 0};

   always @(posedge clk or negedge reset) begin : model
      logic [2:0] sv, lv, rs, fl, tg, lg;
      int         r [3];
      int         a [3];
      int         deb;
      if (!reset) begin
         hist0 <= '0; hist1 <= '0;
         m_level <= '0; m_rise <= '0; m_fall <= '0; m_tog <= '0; m_long <= '0;
         run <= '{0, 0, 0}; age <= '{0, 0, 0};
      end else begin
         sv = hist1 ^ AL;
         lv = m_level; tg = m_tog; rs = '0; fl = '0; lg = '0;
         r = run; a = age;
         for (int c = 0; c < 3; c++) begin
            deb = SLOW[c] ? 8 : 4;
            if (sv[c] != lv[c]) begin
               r[c] = r[c] + 1;
               if (r[c] == deb) begin
                  lv[c] = ~lv[c];
                  r[c] = 0;
                  if (lv[c]) rs[c] = 1'b1; else fl[c] = 1'b1;
               end
            end else begin
               r[c] = 0;
            end
            if (rs[c]) a[c] = 0;
            else if (m_level[c] && !fl[c] && a[c] < LONG) begin
               a[c] = a[c] + 1;
               if (a[c] == LONG) lg[c] = 1'b1;
            end
            if (clr_toggle[c]) tg[c] = 1'b0;
            else if (fl[c]) tg[c] = ~tg[c];
         end
         hist1 <= hist0; hist0 <= raw_in;
         m_level <= lv; m_rise <= rs; m_fall <= fl; m_tog <= tg; m_long <= lg;
         run <= r; age <= a;
      end
   end

   always @(negedge clk) begin
      total += 5;
      if (level !== m_level) begin
         bad++; $display("FAIL model level t=%0t got=%b want=%b", $time, level, m_level);
      end
      if (rise_pulse !== m_rise) begin
         bad++; $display("FAIL model rise t=%0t got=%b want=%b", $time, rise_pulse, m_rise);
      end
      if (fall_pulse !== m_fall) begin
         bad++; $display("FAIL model fall t=%0t got=%b want=%b", $time, fall_pulse, m_fall);
      end
      if (toggle !== m_tog) begin
         bad++; $display("FAIL model toggle t=%0t got=%b want=%b", $time, toggle, m_tog);
      end
      if (long_pulse !== m_long) begin
         bad++; $display("FAIL model long t=%0t got=%b want=%b", $time, long_pulse, m_long);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   int long_cnt;
   int long_at;

   initial begin
      // Reset with all pins high
      step(3);
      chk("rst_level", 32'(level), 0);
      chk("rst_rise", 32'(rise_pulse), 0);
      chk("rst_fall", 32'(fall_pulse), 0);
      chk("rst_toggle", 32'(toggle), 0);
      chk("rst_long", 32'(long_pulse), 0);
      reset = 1'b1;
      step(5);
      chk("post_rst_e5_level", 32'(level), 0);
      step(1);
      chk("post_rst_e6_level", 32'(level), 32'b001);
      chk("post_rst_e6_rise", 32'(rise_pulse), 32'b001);
      step(4);
      chk("post_rst_e10_level", 32'(level), 32'b101);
      chk("post_rst_e10_rise", 32'(rise_pulse), 32'b100);
      step(30);
      raw_in = 3'b010;
      step(10);
      chk("release_toggles", 32'(toggle), 32'b101);
      clr_toggle = 3'b111;
      step(1);
      clr_toggle = 3'b000;
      chk("clr_all_toggle", 32'(toggle), 0);

      // Clean press / release on ch0
      raw_in = 3'b011;
      step(5);
      chk("press_e5_level0", 32'(level[0]), 0);
      step(1);
      chk("press_e6_rise0", 32'(rise_pulse[0]), 1);
      chk("press_e6_level0", 32'(level[0]), 1);
      step(1);
      chk("press_e7_rise0", 32'(rise_pulse[0]), 0);
      step(3);
      raw_in = 3'b010;
      step(5);
      chk("rel_e5_level0", 32'(level[0]), 1);
      step(1);
      chk("rel_e6_fall0", 32'(fall_pulse[0]), 1);
      chk("rel_e6_toggle0", 32'(toggle[0]), 1);
      step(1);
      chk("rel_e7_fall0", 32'(fall_pulse[0]), 0);

      // Bounce shorter than DEB, then glitch while pressed
      raw_in[0] = 1'b1; step(3);
      raw_in[0] = 1'b0; step(1);
      raw_in[0] = 1'b1; step(3);
      raw_in[0] = 1'b0; step(10);
      chk("bounce_level0", 32'(level[0]), 0);
      raw_in[0] = 1'b1; step(8);
      chk("held_level0", 32'(level[0]), 1);
      raw_in[0] = 1'b0; step(2);
      raw_in[0] = 1'b1; step(8);
      chk("glitch_level0", 32'(level[0]), 1);
      raw_in[0] = 1'b0; step(8);
      chk("bounce_rel_level0", 32'(level[0]), 0);
      chk("bounce_rel_toggle0", 32'(toggle[0]), 0);

      // Inverted fast ch1, slow ch2
      raw_in = 3'b000;
      step(5);
      chk("inv_e5_level1", 32'(level[1]), 0);
      step(1);
      chk("inv_e6_level1", 32'(level[1]), 1);
      chk("inv_e6_rise1", 32'(rise_pulse[1]), 1);
      raw_in = 3'b100;
      step(9);
      chk("slow_e9_level2", 32'(level[2]), 0);
      step(1);
      chk("slow_e10_level2", 32'(level[2]), 1);
      chk("slow_e10_rise2", 32'(rise_pulse[2]), 1);
      raw_in = 3'b000;
      step(12);
      chk("slow_rel_level2", 32'(level[2]), 0);
      raw_in = 3'b100; step(7);
      raw_in = 3'b000; step(12);
      chk("slow_short_level2", 32'(level[2]), 0);
      raw_in = 3'b010;
      step(10);
      chk("inv_rel_level1", 32'(level[1]), 0);

      // Long press with a 2-cycle glitch at cycle 10 of the press
      raw_in = 3'b011;
      step(6);
      chk("long_rise0", 32'(rise_pulse[0]), 1);
      long_cnt = 0;
      long_at = -1;
      for (int i = 1; i <= 34; i++) begin
         if (i == 5) raw_in[0] = 1'b0;
         if (i == 7) raw_in[0] = 1'b1;
         step(1);
         if (long_pulse[0]) begin
            long_cnt++;
            long_at = i;
         end
      end
      chk("long_count0", 32'(long_cnt), 1);
      chk("long_edge0", 32'(long_at), 20);
      chk("long_level0", 32'(level[0]), 1);

      // Clear coinciding with the fall pulse
      clr_toggle = 3'b001; step(1);
      clr_toggle = 3'b000;
      raw_in = 3'b010;
      step(5);
      clr_toggle = 3'b001;
      step(1);
      clr_toggle = 3'b000;
      chk("clr_fall_fall0", 32'(fall_pulse[0]), 1);
      chk("clr_fall_toggle0", 32'(toggle[0]), 0);
      step(2);

      // Reset mid-press
      raw_in = 3'b011;
      step(6);
      chk("mid_level0", 32'(level[0]), 1);
      step(2);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_level0", 32'(level[0]), 0);
      chk("mid_rst_fall0", 32'(fall_pulse[0]), 0);
      chk("mid_rst_toggle0", 32'(toggle[0]), 0);
      @(negedge clk);
      raw_in = 3'b010;
      step(2);
      reset = 1'b1;
      step(12);
      chk("final_level", 32'(level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
